gpr_halt_seq: RTL and testbench

Halt sequencer for the simulation core's general-purpose register file. On an `ebreak` commit it freezes the pipeline, waits for outstanding writebacks to drain, and captures the exit code from `a0` (x10). It then streams the architectural register state out over a valid/ready port for the testbench, and finally raises a sticky `sim_done`. It sits between commit/writeback and a spare read port of the GPR file, and replaces ad-hoc `$finish` handling.

---
 rtl/gpr_halt_pkg.sv | 14 +
 rtl/gpr_drain_timer.sv | 36 +++
 rtl/gpr_halt_seq.sv | 126 ++++++++++++
 tb/tb_gpr_halt_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_halt_pkg.sv
// Shared types and register indices for the GPR halt sequencer.
package gpr_halt_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StDump  = 2'd2,
        StDone  = 2'd3
    } halt_state_e;

    localparam int unsigned GPR_A0_IDX   = 10;
    localparam int unsigned GPR_ZERO_IDX = 0;

endpackage

// File: rtl/gpr_drain_timer.sv
// Saturating DRAIN cycle counter; expired is high once DRAIN_MAX cycles have been counted.
module gpr_drain_timer #(
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/gpr_halt_seq.sv
// Halt sequencer: freezes on ebreak, drains writebacks, captures a0, optionally dumps the GPRs.
// Define GPR_HALT_DUMP_EN to build the DUMP stage; otherwise DRAIN exits straight to DONE.
module gpr_halt_seq
    import gpr_halt_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned NREG      = 32,
    parameter int unsigned DRAIN_MAX = 15,
    localparam int unsigned IW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halt_req,
    input  logic            wb_busy,
    output logic            stall,
    output logic [IW-1:0]   rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [IW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic [XLEN-1:0] exit_code,
    output logic            good_trap,
    output logic            drain_to,
    output logic            sim_done
);

    halt_state_e     state_q, state_d;
    logic            timer_clr, timer_en, expired, drain_exit;
    logic [XLEN-1:0] exit_code_q;
    logic            good_trap_q, drain_to_q;

    assign timer_clr  = (state_q == StIdle);
    assign timer_en   = (state_q == StDrain);
    // Leave DRAIN once writebacks settle, or force out when the timer runs out.
    assign drain_exit = (state_q == StDrain) && (!wb_busy || expired);

    gpr_drain_timer #(
        .DRAIN_MAX(DRAIN_MAX)
    ) u_drain_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(expired)
    );

`ifdef GPR_HALT_DUMP_EN
    logic [IW-1:0] dump_idx_q;
    logic          dump_hs, dump_last;

    assign dump_hs   = (state_q == StDump) && dump_ready;
    assign dump_last = (dump_idx_q == IW'(NREG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_idx_q <= '0;
        end else if (dump_hs) begin
            dump_idx_q <= dump_last ? '0 : dump_idx_q + 1'b1;
        end
    end

    assign dump_valid = (state_q == StDump);
    assign dump_idx   = dump_idx_q;
    // x0 is architecturally zero regardless of what the array holds.
    assign dump_data  = (dump_valid && (dump_idx_q != IW'(GPR_ZERO_IDX))) ? rf_rdata : '0;
`else
    logic unused_dump_ready;
    assign unused_dump_ready = dump_ready;
    assign dump_valid        = 1'b0;
    assign dump_idx          = '0;
    assign dump_data         = '0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (halt_req) state_d = StDrain;
`ifdef GPR_HALT_DUMP_EN
            StDrain: if (drain_exit) state_d = StDump;
            StDump:  if (dump_hs && dump_last) state_d = StDone;
`else
            StDrain: if (drain_exit) state_d = StDone;
            StDump:  state_d = StDone;
`endif
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rf_raddr = '0;
        if (state_q == StDrain) begin
            rf_raddr = IW'(GPR_A0_IDX);
        end
`ifdef GPR_HALT_DUMP_EN
        else if (state_q == StDump) begin
            rf_raddr = dump_idx_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            exit_code_q <= '0;
            good_trap_q <= 1'b0;
            drain_to_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (drain_exit) begin
                exit_code_q <= rf_rdata;
                good_trap_q <= (rf_rdata == '0);
                drain_to_q  <= wb_busy;
            end
        end
    end

    // Combinational so the instruction behind ebreak is held in the same cycle.
    assign stall     = (state_q == StIdle) ? halt_req : 1'b1;
    assign sim_done  = (state_q == StDone);
    assign exit_code = exit_code_q;
    assign good_trap = good_trap_q;
    assign drain_to  = drain_to_q;

endmodule

// File: tb/tb_gpr_halt_seq.sv
// Self-checking bench for gpr_halt_seq; follows GPR_HALT_DUMP_EN to match the DUT build.
`timescale 1ns/1ps
module tb_gpr_halt_seq;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned NREG      = 32;
    localparam int unsigned DRAIN_MAX = 15;
    localparam int unsigned IW        = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            halt_req = 1'b0;
    logic            wb_busy = 1'b0;
    logic            dump_ready = 1'b0;
    logic            stall, dump_valid, good_trap, drain_to, sim_done;
    logic [IW-1:0]   rf_raddr, dump_idx;
    logic [XLEN-1:0] rf_rdata, dump_data, exit_code;

    logic [XLEN-1:0] regs [NREG];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rf_rdata = regs[rf_raddr];

    gpr_halt_seq #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .DRAIN_MAX(DRAIN_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .halt_req  (halt_req),
        .wb_busy   (wb_busy),
        .stall     (stall),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_idx  (dump_idx),
        .dump_data (dump_data),
        .exit_code (exit_code),
        .good_trap (good_trap),
        .drain_to  (drain_to),
        .sim_done  (sim_done)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, XLEN'(stall), 0);
        chk({tag, "_dump_valid"}, XLEN'(dump_valid), 0);
        chk({tag, "_sim_done"}, XLEN'(sim_done), 0);
        chk({tag, "_drain_to"}, XLEN'(drain_to), 0);
        chk({tag, "_good_trap"}, XLEN'(good_trap), 0);
        chk({tag, "_exit_code"}, exit_code, 0);
        chk({tag, "_dump_idx"}, XLEN'(dump_idx), 0);
        chk({tag, "_rf_raddr"}, XLEN'(rf_raddr), 0);
        chk({tag, "_dump_data"}, dump_data, 0);
    endtask

    task automatic do_reset();
        halt_req   = 1'b0;
        wb_busy    = 1'b0;
        dump_ready = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");
        tick();
    endtask

    task automatic fill_regs(input logic [XLEN-1:0] x10);
        for (int i = 0; i < int'(NREG); i++) regs[i] = {$urandom, $urandom};
        regs[0]  = 64'hFFFF;
        regs[10] = x10;
    endtask

    // Pull reset mid-cycle and expect every output to clear without a clock edge.
    task automatic async_reset_check(input string tag);
        halt_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero(tag);
    endtask

    // k = cycles wb_busy stays high in DRAIN; mode 0 ready high, 1 backpressure at idx 5,
    // 2 random ready; reset_at >= 0 aborts with an async reset.
    task automatic run_halt(input int k, input int mode, input bit new_x10,
                            input logic [XLEN-1:0] x10_val, input int reset_at);
        int ndrain, tcount, exp_idx, hold, cyc;
        bit exp_to;
        logic [XLEN-1:0] exp_code;

        ndrain = (k < int'(DRAIN_MAX)) ? k + 1 : int'(DRAIN_MAX) + 1;
        exp_to = (k > int'(DRAIN_MAX));
        tcount = 0;
        exp_code = regs[10];

        halt_req = 1'b1;
        wb_busy  = 1'(k > 0);
        @(negedge clk);
        chk("stall_at_T", XLEN'(stall), 1);
        chk("sim_done_at_T", XLEN'(sim_done), 0);
        tick(); tcount++;

        for (int c = 0; c < ndrain; c++) begin
            halt_req = 1'($urandom_range(0, 1));
            wb_busy  = 1'(c < k);
            if (new_x10 && c == ndrain - 1) regs[10] = x10_val;
            @(negedge clk);
            exp_code = regs[10];
            chk("drain_raddr", XLEN'(rf_raddr), 10);
            chk("drain_stall", XLEN'(stall), 1);
            chk("drain_not_left", XLEN'({dump_valid, sim_done}), 0);
            chk("drain_dump_idx", XLEN'(dump_idx), 0);
            tick(); tcount++;
        end
        wb_busy = 1'($urandom_range(0, 1));

        @(negedge clk);
        chk("exit_code", exit_code, exp_code);
        chk("drain_to", XLEN'(drain_to), XLEN'(exp_to));

`ifdef GPR_HALT_DUMP_EN
        exp_idx = 0;
        hold = 0;
        cyc = 0;
        while (exp_idx < int'(NREG) && cyc < 400) begin
            if (mode == 1 && exp_idx == 5 && hold < 3) begin
                dump_ready = 1'b0;
                hold++;
            end else if (mode == 2) begin
                dump_ready = 1'($urandom_range(0, 3) != 0);
            end else begin
                dump_ready = 1'b1;
            end
            @(negedge clk);
            chk("dump_valid", XLEN'(dump_valid), 1);
            chk("dump_idx", XLEN'(dump_idx), XLEN'(exp_idx));
            chk("dump_data", dump_data, (exp_idx == 0) ? '0 : regs[exp_idx]);
            chk("dump_raddr", XLEN'(rf_raddr), XLEN'(exp_idx));
            chk("dump_sim_done", XLEN'(sim_done), 0);
            if (exp_idx == reset_at) begin
                async_reset_check("mid_dump_reset");
                return;
            end
            if (dump_ready) exp_idx++;
            tick(); tcount++; cyc++;
        end
        chk("dump_beats", XLEN'(exp_idx), XLEN'(NREG));
        if (mode == 1) chk("bp_hold_cycles", XLEN'(hold), 3);
        if (mode == 0) chk("done_latency", XLEN'(tcount), XLEN'(1 + ndrain + int'(NREG)));
`else
        if (mode == 0) chk("done_latency", XLEN'(tcount), XLEN'(1 + ndrain));
`endif

        for (int d = 0; d < 3; d++) begin
            halt_req   = 1'($urandom_range(0, 1));
            dump_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("done_sim_done", XLEN'(sim_done), 1);
            chk("done_stall", XLEN'(stall), 1);
            chk("done_dump_valid", XLEN'(dump_valid), 0);
            chk("done_dump_data", dump_data, 0);
            chk("done_good_trap", XLEN'(good_trap), XLEN'(exp_code == '0));
            chk("done_exit_code", exit_code, exp_code);
            chk("done_drain_to", XLEN'(drain_to), XLEN'(exp_to));
            tick();
        end
        if (reset_at >= 0) async_reset_check("done_reset");
    endtask

    initial begin
        fill_regs('0);
        do_reset();

        // clean halt, x10 = 0
        run_halt(0, 0, 1'b0, '0, -1);

        // backpressure at index 5, nonzero exit code
        do_reset();
        fill_regs(64'h1234_5678_9ABC_DEF0);
        run_halt(int'($urandom_range(0, 3)), 1, 1'b0, '0, -1);

        // drain wait, x10 written during DRAIN
        do_reset();
        fill_regs(64'h5);
        run_halt(4, 0, 1'b1, 64'h2A, -1);

        // drain timeout and both sides of the boundary
        do_reset();
        fill_regs(64'h0);
        run_halt(60, 0, 1'b0, '0, -1);
        do_reset();
        fill_regs(64'h7);
        run_halt(15, 0, 1'b0, '0, -1);
        do_reset();
        fill_regs(64'h0);
        run_halt(16, 2, 1'b0, '0, -1);

        // reset mid-dump (or in DONE without the dump stage), then restart
        do_reset();
        fill_regs({$urandom, $urandom});
        run_halt(2, 0, 1'b0, '0, 12);
        do_reset();
        run_halt(0, 0, 1'b0, '0, -1);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            fill_regs(($urandom_range(0, 1) == 0) ? '0 : {$urandom, $urandom});
            run_halt(int'($urandom_range(0, 20)), 2, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 0) ? '0 : {$urandom, $urandom}, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
